// File: rtl/fir_seq_pkg.sv
// Shared definitions for the time-multiplexed FIR sequencer.
//   fir_seq_state_t : sequencer states CLEAR, IDLE, MAC, DRAIN, OUT
//   FIR_SEQ_*       : default sample / coefficient / accumulator widths
//   fir_seq_scale() : accumulator -> output sample conversion. It drops N-1
//                     fraction bits. Saturation is added when FIR_SEQ_SAT_EN
//                     is defined.
package fir_seq_pkg;

  typedef enum logic [2:0] {CLEAR, IDLE, MAC, DRAIN, OUT} fir_seq_state_t;

  localparam int unsigned FIR_SEQ_N       = 24;
  localparam int unsigned FIR_SEQ_N_COEFF = 16;
  localparam int unsigned FIR_SEQ_ACC_W   = 2 * FIR_SEQ_N;

  // The caller passes acc sign-extended to 128 bits. The bits above ACC_W-1
  // copy the sign bit, so an all-equal test on acc[127:2n-2] gives the same
  // result as a test on acc[ACC_W-1:2n-2]. The caller keeps the low n bits.
  function automatic logic [63:0] fir_seq_scale(input logic signed [127:0] acc,
                                                input int unsigned       n);
    logic [63:0] res;
    res = 64'(acc >>> (n - 1));
`ifdef FIR_SEQ_SAT_EN
    begin : sat
      logic signed [127:0] hi;
      hi = acc >>> (2 * n - 2);
      if (hi != '0 && hi != '1) begin
        if (acc[127]) res = ~64'(0) << (n - 1);
        else          res = (64'(1) << (n - 1)) - 64'(1);
      end
    end
`endif
    return res;
  endfunction

endpackage

// File: rtl/fir_seq_mac.sv
// Shared multiply-accumulate datapath for the FIR sequencer.
// The multiplier output is registered and added to the accumulator one cycle
// later.
//   clk, reset : clock and synchronous active-high reset
//   clr        : zeroes the accumulator, which starts a new output sample
//   en         : adds the registered product to the accumulator
//   x, b       : sample and coefficient operands, both signed
//   y_next     : scaled value of the accumulator after this cycle's add
module fir_seq_mac
  import fir_seq_pkg::*;
#(
  parameter int unsigned N       = FIR_SEQ_N,
  parameter int unsigned N_COEFF = FIR_SEQ_N_COEFF,
  parameter int unsigned ACC_W   = 2 * N
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  input  logic                      en,
  input  logic signed [N-1:0]       x,
  input  logic signed [N_COEFF-1:0] b,
  output logic        [N-1:0]       y_next
);

  localparam int unsigned PW = N + N_COEFF;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_d;

  always_ff @(posedge clk) begin
    if (reset) prod <= '0;
    else       prod <= PW'(x) * PW'(b);
  end

  always_comb acc_d = acc + ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (reset || clr) acc <= '0;
    else if (en)      acc <= acc_d;
  end

  // The output register in the sequencer captures this value on the DRAIN
  // edge, so it must already include the last product.
  assign y_next = N'(fir_seq_scale(128'(acc_d), N));

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR engine. One shared multiplier/accumulator runs over
// all N_TAPS taps for each input sample. This block holds the circular
// sample buffer, a run-time writable coefficient bank and the FSM.
//   clk, reset              : clock and synchronous active-high reset
//   data_in/in_valid/in_ready   : input sample handshake
//   data_out/out_valid/out_ready: filtered sample handshake
//   coef_we/coef_addr/coef_wdata: coefficient write port. Writes are ignored
//                                 in CLEAR and when coef_addr >= N_TAPS.
//   busy                    : high whenever the FSM is not in IDLE
// Optional build macro: FIR_SEQ_SAT_EN saturates data_out instead of wrapping.
module fir_mac_sequencer
  import fir_seq_pkg::*;
#(
  parameter int unsigned N       = FIR_SEQ_N,
  parameter int unsigned N_COEFF = FIR_SEQ_N_COEFF,
  parameter int unsigned N_TAPS  = 61,
  parameter int unsigned ACC_W   = 2 * N
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N-1:0]              data_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [N-1:0]              data_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      coef_we,
  input  logic [$clog2(N_TAPS)-1:0] coef_addr,
  input  logic [N_COEFF-1:0]        coef_wdata,
  output logic                      busy
);

  localparam int unsigned AW   = $clog2(N_TAPS);
  localparam logic [AW-1:0] LAST = AW'(N_TAPS - 1);

  fir_seq_state_t state, state_d;
  logic [AW-1:0]      cnt;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_idx;
  logic [AW:0]        rd_sum;
  logic [N-1:0]       sbuf [N_TAPS];
  logic [N_COEFF-1:0] coef [N_TAPS];
  logic               mac_clr, mac_en;
  logic [N-1:0]       y_next;

  // Sample read index is (wr_ptr - k) mod N_TAPS, with k = cnt.
  always_comb begin
    rd_sum = {1'b0, wr_ptr} + (AW+1)'(N_TAPS) - {1'b0, cnt};
    if (rd_sum >= (AW+1)'(N_TAPS)) rd_sum = rd_sum - (AW+1)'(N_TAPS);
    rd_idx = rd_sum[AW-1:0];
  end

  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    case (state)
      CLEAR: if (cnt == LAST) state_d = IDLE;
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_d = MAC;
          mac_clr = 1'b1;
        end
      end
      MAC: begin
        // The product for tap k arrives one cycle late, so nothing is
        // added in the k=0 cycle.
        mac_en = (cnt != '0);
        if (cnt == LAST) state_d = DRAIN;
      end
      DRAIN: begin
        mac_en  = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLEAR;
      cnt      <= '0;
      wr_ptr   <= '0;
      data_out <= '0;
    end else begin
      state <= state_d;
      if (state == CLEAR || state == MAC) cnt <= (cnt == LAST) ? '0 : cnt + AW'(1);
      else                                cnt <= '0;
      if (state == OUT && out_ready) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
      if (state == DRAIN) data_out <= y_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_TAPS; i++) coef[i] <= '0;
    end else if (coef_we && state != CLEAR && {1'b0, coef_addr} < (AW+1)'(N_TAPS)) begin
      coef[coef_addr] <= coef_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR)                 sbuf[cnt]    <= '0;
    else if (state == IDLE && in_valid) sbuf[wr_ptr] <= data_in;
  end

  fir_seq_mac #(
    .N       (N),
    .N_COEFF (N_COEFF),
    .ACC_W   (ACC_W)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clr    (mac_clr),
    .en     (mac_en),
    .x      (sbuf[rd_idx]),
    .b      (coef[cnt]),
    .y_next (y_next)
  );

endmodule

// File: tb/tb_fir_mac_sequencer.sv
module tb_fir_mac_sequencer;

  localparam int unsigned NT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] data_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] data_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        coef_we = 1'b0;
  logic [2:0]  coef_addr = '0;
  logic [15:0] coef_wdata = '0;
  logic        busy;

  fir_mac_sequencer #(.N(24), .N_COEFF(16), .N_TAPS(NT)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: every accepted sample since reset, plus the coefficients
  // that were written.
  logic signed [23:0] hist[$];
  logic signed [15:0] mb[NT];

  typedef struct {
    logic [23:0] x;
    logic [23:0] exp;
    int          stall;
  } vec_t;

  vec_t t2[9];
  vec_t t4[25];

  function automatic logic [23:0] model_y();
    longint s = 0;
    longint a;
    int n = hist.size();
    for (int k = 0; k < int'(NT); k++)
      if (n - 1 - k >= 0) s += longint'(mb[k]) * longint'(hist[n-1-k]);
    a = (s <<< 16) >>> 16;
`ifdef FIR_SEQ_SAT_EN
    if (a >= (longint'(1) <<< 46)) return 24'h7FFFFF;
    if (a < -(longint'(1) <<< 46)) return 24'h800000;
`endif
    return 24'(a >>> 23);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    foreach (mb[i]) mb[i] = '0;
  endtask

  task automatic do_reset(input int cyc);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; coef_we = 1'b0;
    repeat (cyc) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
    chk("wait_idle", 64'(in_ready), 64'(1));
  endtask

  task automatic write_coef(input int k, input logic [15:0] v);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 3'(k); coef_wdata = v;
    @(negedge clk);
    coef_we = 1'b0;
    mb[k] = v;
  endtask

  // Sends one sample, then checks the latency, the held output during the
  // stall cycles and the handshake back to IDLE.
  task automatic send(input string nm, input logic [23:0] x, input logic [23:0] exp, input int stall);
    int lat;
    wait_idle();
    data_in = x; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(NT + 2));
    for (int i = 0; i < stall; i++) begin
      chk({nm, "_stall_valid"}, 64'(out_valid), 64'(1));
      chk({nm, "_stall_ready"}, 64'(in_ready), 64'(0));
      chk({nm, "_stall_data"}, 64'(data_out), 64'(exp));
      @(negedge clk);
    end
    chk({nm, "_data"}, 64'(data_out), 64'(exp));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_valid_drop"}, 64'(out_valid), 64'(0));
    chk({nm, "_ready_back"}, 64'(in_ready), 64'(1));
  endtask

  task automatic load_ramp();
    for (int k = 0; k < int'(NT); k++) write_coef(k, 16'((k + 1) << 12));
  endtask

  task automatic apply_t2(input string tag);
    for (int i = 0; i < 9; i++) begin
      hist.push_back(t2[i].x);
      send(tag, t2[i].x, t2[i].exp, t2[i].stall);
    end
  endtask

  initial begin
    logic [23:0] rx;
    // b[7] = 16'h8000 is negative as a signed coefficient, so output 8 is -8.
    for (int i = 0; i < 9; i++) begin
      t2[i] = '{x: (i == 0) ? 24'h000800 : 24'h0, exp: 24'(i + 1), stall: (i == 0) ? 10 : 0};
    end
    t2[7].exp = 24'hFFFFF8;
    t2[8].exp = 24'h0;
    for (int i = 0; i < 25; i++)
      t4[i] = '{x: 24'h000800, exp: 24'((i < 8) ? i + 1 : 8), stall: 0};

    // 1: reset and CLEAR timing. A coefficient write made during CLEAR must be dropped.
    do_reset(3);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_data_out", 64'(data_out), 64'(0));
    for (int i = 0; i < int'(NT); i++) begin
      chk("clear_in_ready", 64'(in_ready), 64'(0));
      chk("clear_busy", 64'(busy), 64'(1));
      coef_we = (i == 2); coef_addr = 3'd0; coef_wdata = 16'h1000;
      @(negedge clk);
    end
    coef_we = 1'b0;
    chk("idle_in_ready", 64'(in_ready), 64'(1));
    chk("idle_busy", 64'(busy), 64'(0));
    hist.push_back(24'h000800);
    send("clear_write_ignored", 24'h000800, model_y(), 0);

    // 2 + 3: impulse through the ramp coefficients; the first output is held for 10 cycles.
    do_reset(2);
    wait_idle();
    load_ramp();
    apply_t2("impulse");

    // 4: constant input, wrapping wr_ptr three times
    do_reset(2);
    wait_idle();
    for (int k = 0; k < int'(NT); k++) write_coef(k, 16'h1000);
    for (int i = 0; i < 25; i++) begin
      hist.push_back(t4[i].x);
      send("step", t4[i].x, t4[i].exp, t4[i].stall);
    end

    // 5: full-scale inputs against the model
    do_reset(2);
    wait_idle();
    for (int k = 0; k < int'(NT); k++) write_coef(k, 16'h7FFF);
    for (int i = 0; i < 20; i++) begin
      rx = (i < 10) ? 24'h7FFFFF : 24'h800000;
      hist.push_back(rx);
      send("fullscale", rx, model_y(), 0);
    end

    // Random coefficients and samples, with one coefficient rewrite partway through
    do_reset(2);
    wait_idle();
    for (int k = 0; k < int'(NT); k++) write_coef(k, 16'($urandom));
    for (int i = 0; i < 24; i++) begin
      if (i == 12) begin
        wait_idle();
        write_coef(int'($urandom_range(NT - 1)), 16'($urandom));
      end
      rx = 24'($urandom);
      hist.push_back(rx);
      send("random", rx, model_y(), int'($urandom_range(2)));
    end

    // 6: reset in MAC cycle k=3; the following impulse must show no residue from the aborted sample
    do_reset(2);
    wait_idle();
    load_ramp();
    wait_idle();
    data_in = 24'h7FFFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_busy", 64'(busy), 64'(1));
    chk("abort_in_ready", 64'(in_ready), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("abort_reclear", 64'(in_ready), 64'(0));
    wait_idle();
    load_ramp();
    apply_t2("post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
